mmio_host_master: RTL and testbench

- On-chip MMIO requester that drives the host-to-AFU side of the MMIO interface: issues 64-bit MMIO writes and reads, then collects read responses.
- Used in loopback self-test builds and unit benches to exercise AFU register maps (DFH at 16'h0000, user register at 16'h0020) without a host.
- Accepts one command at a time on a valid/ready interface and returns one result per command.

---
 rtl/mmio_host_master.sv | 188 ++++++++++++++++++
 tb/tb_mmio_host_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_master.sv
// mmio_host_master: single-outstanding MMIO requester for the host-to-AFU side.
// Accepts one command on cmd_valid/cmd_ready, issues one 64-bit MMIO write or
// read, waits for the read response or a timeout, and returns one result pulse.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cmd_*             command in (valid/ready, wr, DWORD addr, write data)
//   res_*             result out (one-cycle valid, read data, timeout flag)
//   mmio_*            request out (wr/rd strobes, addr, tid, length, wdata)
//   rsp_*             read response in (valid, tid, data)
//   stray_cnt         saturating count of unexpected or ignored responses
//
// Optional build macro: MMIO_HOST_TID_CHECK_EN -- when defined, a read response
// is only accepted if rsp_tid equals the TID issued for the current read.
module mmio_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TID_W          = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [15:0]      cmd_addr,
  input  logic [63:0]      cmd_wdata,
  output logic             res_valid,
  output logic [63:0]      res_data,
  output logic             res_timeout,
  output logic             mmio_wr_valid,
  output logic             mmio_rd_valid,
  output logic [15:0]      mmio_addr,
  output logic [TID_W-1:0] mmio_tid,
  output logic [1:0]       mmio_length,
  output logic [63:0]      mmio_wdata,
  input  logic             rsp_valid,
  input  logic [TID_W-1:0] rsp_tid,
  input  logic [63:0]      rsp_data,
  output logic [15:0]      stray_cnt
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TMO_W  = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_e;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [TID_W-1:0]    tid_q, tid_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_timeout_q, res_timeout_d;
  logic                mmio_wr_valid_q, mmio_wr_valid_d;
  logic                mmio_rd_valid_q, mmio_rd_valid_d;
  logic [ADDR_W-1:0]   mmio_addr_q, mmio_addr_d;
  logic [TID_W-1:0]    mmio_tid_q, mmio_tid_d;
  logic [DATA_W-1:0]   mmio_wdata_q, mmio_wdata_d;
  logic [CNT_W-1:0]    stray_q, stray_d;
  logic                tid_ok_c;

  // Response TID qualification; mmio_tid_q holds the TID of the current read.
`ifdef MMIO_HOST_TID_CHECK_EN
  assign tid_ok_c = (rsp_tid == mmio_tid_q);
`else
  logic unused_rsp_tid;
  assign unused_rsp_tid = ^rsp_tid;
  assign tid_ok_c       = 1'b1;
`endif

  // Next-state, request and result logic.
  always_comb begin
    state_d         = state_q;
    wr_d            = wr_q;
    tid_d           = tid_q;
    tmo_d           = tmo_q;
    mmio_addr_d     = mmio_addr_q;
    mmio_tid_d      = mmio_tid_q;
    mmio_wdata_d    = mmio_wdata_q;
    stray_d         = stray_q;
    mmio_wr_valid_d = 1'b0;
    mmio_rd_valid_d = 1'b0;
    res_valid_d     = 1'b0;
    res_data_d      = '0;
    res_timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d            = cmd_wr;
          mmio_addr_d     = cmd_addr;
          mmio_wdata_d    = cmd_wdata;
          mmio_tid_d      = tid_q;
          mmio_wr_valid_d = cmd_wr;
          mmio_rd_valid_d = !cmd_wr;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        tid_d = tid_q + TID_W'(1);
        if (wr_q) begin
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          tmo_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A match in the final timeout cycle still wins.
        if (rsp_valid && tid_ok_c) begin
          res_valid_d = 1'b1;
          res_data_d  = rsp_data;
          state_d     = DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
          state_d       = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);

    // Anything not consumed as the current read's response is stray.
    if (rsp_valid && !((state_q == WAIT_RSP) && tid_ok_c) && (stray_q != {CNT_W{1'b1}})) begin
      stray_d = stray_q + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wr_q            <= 1'b0;
      tid_q           <= '0;
      tmo_q           <= '0;
      cmd_ready_q     <= 1'b0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_timeout_q   <= 1'b0;
      mmio_wr_valid_q <= 1'b0;
      mmio_rd_valid_q <= 1'b0;
      mmio_addr_q     <= '0;
      mmio_tid_q      <= '0;
      mmio_wdata_q    <= '0;
      stray_q         <= '0;
    end else begin
      state_q         <= state_d;
      wr_q            <= wr_d;
      tid_q           <= tid_d;
      tmo_q           <= tmo_d;
      cmd_ready_q     <= cmd_ready_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      res_timeout_q   <= res_timeout_d;
      mmio_wr_valid_q <= mmio_wr_valid_d;
      mmio_rd_valid_q <= mmio_rd_valid_d;
      mmio_addr_q     <= mmio_addr_d;
      mmio_tid_q      <= mmio_tid_d;
      mmio_wdata_q    <= mmio_wdata_d;
      stray_q         <= stray_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_timeout   = res_timeout_q;
  assign mmio_wr_valid = mmio_wr_valid_q;
  assign mmio_rd_valid = mmio_rd_valid_q;
  assign mmio_addr     = mmio_addr_q;
  assign mmio_tid      = mmio_tid_q;
  assign mmio_length   = 2'b01;
  assign mmio_wdata    = mmio_wdata_q;
  assign stray_cnt     = stray_q;

endmodule

// File: tb/tb_mmio_host_master.sv
// tb_mmio_host_master: self-checking bench for mmio_host_master.
// Table vectors, hand-written corner sequences and randomized commands, all
// compared against expectations derived from the command/response rules.
module tb_mmio_host_master;

  localparam int unsigned TMO = 12;
  localparam int unsigned TW  = 9;
`ifdef MMIO_HOST_TID_CHECK_EN
  localparam bit TID_CHK = 1'b1;
`else
  localparam bit TID_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [15:0]   cmd_addr;
  logic [63:0]   cmd_wdata;
  logic          res_valid, res_timeout;
  logic [63:0]   res_data;
  logic          mmio_wr_valid, mmio_rd_valid;
  logic [15:0]   mmio_addr;
  logic [TW-1:0] mmio_tid;
  logic [1:0]    mmio_length;
  logic [63:0]   mmio_wdata;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tid;
  logic [63:0]   rsp_data;
  logic [15:0]   stray_cnt;

  int checks = 0;
  int errors = 0;
  int model_tid = 0;
  int model_stray = 0;

  mmio_host_master #(.TIMEOUT_CYCLES(TMO), .TID_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .res_valid(res_valid), .res_data(res_data), .res_timeout(res_timeout),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_length(mmio_length),
    .mmio_wdata(mmio_wdata),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    int          delay;
    logic [63:0] rdata;
    int          lat;
    logic [63:0] data;
    logic        to;
    int          stray;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    model_tid   = 0;
    model_stray = 0;
  endtask

  // Expected result from the rules: the read wait window covers TMO cycles,
  // indexed 0..TMO-1 from the first cycle after the request strobe.
  task automatic model_cmd(input logic wr, input int delay, input logic [63:0] rdata,
                           input bit bad_first, output int lat, output logic [63:0] data,
                           output logic to, output int stray_inc);
    int m;
    stray_inc = 0;
    if (wr) begin
      lat = 2; data = '0; to = 1'b0;
    end else begin
      if (delay < 0) begin
        stray_inc = 1;
        m = -1;
      end else if (TID_CHK && bad_first) begin
        if (delay <= int'(TMO) - 1) stray_inc = 1;
        m = delay + 1;
      end else begin
        m = delay;
      end
      if (m >= 0 && m <= int'(TMO) - 1) begin
        lat = 3 + m; to = 1'b0;
        data = (bad_first && !TID_CHK) ? ~rdata : rdata;
      end else begin
        lat = 2 + int'(TMO); to = 1'b1; data = '0;
      end
    end
  endtask

  // Issue one command and play the AFU responder; delay d puts the response
  // d+1 cycles after the read strobe cycle (-1 = during the strobe cycle).
  task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                        input int delay, input logic [63:0] rdata, input bit bad_first,
                        output int lat, output logic [63:0] rdat, output logic rto,
                        output int nstb, output logic s_wr, output logic [15:0] s_addr,
                        output logic [TW-1:0] s_tid, output logic [63:0] s_wdata);
    int guard, st, t, gt;
    lat = -1; rdat = '0; rto = 1'b0; nstb = 0;
    s_wr = 1'b0; s_addr = '0; s_tid = '0; s_wdata = '0; st = -1;
    guard = 0;
    while (!cmd_ready && guard < 10) begin
      step();
      guard++;
    end
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
    step();
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    t = 1;
    while (t < 64 && lat < 0) begin
      if (mmio_wr_valid || mmio_rd_valid) begin
        nstb++; st = t;
        s_wr = mmio_wr_valid; s_addr = mmio_addr; s_tid = mmio_tid; s_wdata = mmio_wdata;
      end
      if (res_valid) begin
        lat = t; rdat = res_data; rto = res_timeout;
      end else begin
        rsp_valid = 1'b0; rsp_tid = '0; rsp_data = '0;
        gt = st + 1 + delay + (bad_first ? 1 : 0);
        if (st >= 0 && !s_wr) begin
          if (bad_first && t == st + 1 + delay) begin
            rsp_valid = 1'b1; rsp_tid = s_tid - TW'(1); rsp_data = ~rdata;
          end else if (t == gt) begin
            rsp_valid = 1'b1; rsp_tid = s_tid; rsp_data = rdata;
          end
        end
        step();
        t++;
      end
    end
    rsp_valid = 1'b0;
  endtask

  task automatic run_check(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                           input int delay, input logic [63:0] rdata, input bit bad_first,
                           input int exp_lat, input logic [63:0] exp_data, input logic exp_to,
                           input int exp_stray_inc, input string tag);
    int lat, nstb;
    logic [63:0] rdat, s_wdata;
    logic rto, s_wr;
    logic [15:0] s_addr;
    logic [TW-1:0] s_tid;
    do_cmd(wr, addr, wdata, delay, rdata, bad_first, lat, rdat, rto, nstb, s_wr, s_addr, s_tid, s_wdata);
    chk({tag, "_strobes"}, 64'(nstb), 64'd1);
    chk({tag, "_kind"}, 64'(s_wr), 64'(wr));
    chk({tag, "_addr"}, 64'(s_addr), 64'(addr));
    chk({tag, "_tid"}, 64'(s_tid), 64'(model_tid));
    chk({tag, "_wdata"}, s_wdata, wdata);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res_data"}, rdat, exp_data);
    chk({tag, "_timeout"}, 64'(rto), 64'(exp_to));
    model_tid   = (model_tid + 1) % (1 << TW);
    model_stray = model_stray + exp_stray_inc;
    step();
    chk({tag, "_res_clear"}, 64'(res_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_stray"}, 64'(stray_cnt), 64'(model_stray));
  endtask

  task automatic run_model(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                           input int delay, input logic [63:0] rdata, input bit bad_first,
                           input string tag);
    int lat, si;
    logic [63:0] d;
    logic to;
    model_cmd(wr, delay, rdata, bad_first, lat, d, to, si);
    run_check(wr, addr, wdata, delay, rdata, bad_first, lat, d, to, si, tag);
  endtask

  initial begin
    logic seen;
    vecs[0] = '{1'b1, 16'h0020, 64'hDEAD_BEEF_0123_4567, 0,    64'h0, 2,  64'h0, 1'b0, 0};
    vecs[1] = '{1'b0, 16'h0020, 64'h0, 1,    64'hDEAD_BEEF_0123_4567, 4,  64'hDEAD_BEEF_0123_4567, 1'b0, 0};
    vecs[2] = '{1'b0, 16'h0000, 64'h0, 1,    64'h1000_0100_0000_0000, 4,  64'h1000_0100_0000_0000, 1'b0, 0};
    vecs[3] = '{1'b0, 16'h0000, 64'h0, 11,   64'h1000_0100_0000_0000, 14, 64'h1000_0100_0000_0000, 1'b0, 0};
    vecs[4] = '{1'b0, 16'h0020, 64'h0, 1000, 64'h1111_2222_3333_4444, 14, 64'h0, 1'b1, 0};
    vecs[5] = '{1'b0, 16'h0010, 64'h0, 12,   64'h5555_6666_7777_8888, 14, 64'h0, 1'b1, 0};
    vecs[6] = '{1'b0, 16'h0008, 64'h0, 0,    64'h0123_4567_89AB_CDEF, 3,  64'h0123_4567_89AB_CDEF, 1'b0, 0};
    vecs[7] = '{1'b0, 16'h0030, 64'h0, -1,   64'h9999_AAAA_BBBB_CCCC, 14, 64'h0, 1'b1, 1};
    vecs[8] = '{1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0, 2, 64'h0, 1'b0, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_valid = 1'b0; rsp_tid = '0; rsp_data = '0;
    step();
    step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_strobes", 64'({mmio_wr_valid, mmio_rd_valid}), 64'd0);
    chk("rst_tid", 64'(mmio_tid), 64'd0);
    chk("rst_length", 64'(mmio_length), 64'd1);
    chk("rst_stray", 64'(stray_cnt), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_release_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      run_check(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay, vecs[i].rdata, 1'b0,
                vecs[i].lat, vecs[i].data, vecs[i].to, vecs[i].stray, $sformatf("vec%0d", i));
    end

    // Reset during WAIT_RSP drops the read silently.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0020;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    seen = 1'b0;
    step();
    seen = seen | res_valid;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | res_valid;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    chk("midrst_ready", 64'(cmd_ready), 64'd1);
    model_tid = 0;
    model_stray = 0;
    run_model(1'b1, 16'h0020, 64'h0BAD_F00D_0000_0001, 0, 64'h0, 1'b0, "midrst_next");

    // Timeout, then a late response lands in IDLE.
    run_model(1'b0, 16'h0020, 64'h0, 1000, 64'h0, 1'b0, "tmo");
    rsp_valid = 1'b1; rsp_tid = TW'(1); rsp_data = 64'h1234;
    step();
    rsp_valid = 1'b0;
    step();
    chk("late_rsp_stray", 64'(stray_cnt), 64'd1);
    model_stray = 1;

    // Bring the TID to 5, then answer with TID 4 before TID 5.
    for (int i = 0; i < 3; i++) run_model(1'b1, 16'(i * 8), 64'(i), 0, 64'h0, 1'b0, "pre_tid");
    chk("tid_before_check", 64'(model_tid), 64'd5);
    run_model(1'b0, 16'h0020, 64'h0, 1, 64'hA5A5_5A5A_C3C3_3C3C, 1'b1, "tid_check");

    // TID wraps after 2^TW requests.
    do_reset();
    for (int i = 0; i < 513; i++) begin
      run_model(1'b1, 16'(i), 64'(i), 0, 64'h0, 1'b0, "wrap");
    end

    // Randomized commands with idle-time stray responses.
    for (int i = 0; i < 80; i++) begin
      logic wr;
      logic [15:0] addr;
      logic [63:0] wdata, rdata;
      int r, delay, gap;
      bit bad;
      wr    = 1'($urandom_range(0, 1));
      addr  = 16'($urandom);
      wdata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      r     = int'($urandom_range(0, 9));
      delay = (r == 0) ? -1 : (r == 1) ? 40 : int'($urandom_range(0, 14));
      bad   = !wr && delay >= 0 && ($urandom_range(0, 3) == 0);
      run_model(wr, addr, wdata, delay, rdata, bad, "rand");
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1) begin
          rsp_valid = 1'b1; rsp_tid = TW'($urandom); rsp_data = {$urandom, $urandom};
          model_stray++;
        end
        step();
        rsp_valid = 1'b0;
      end
      step();
      chk("rand_idle_stray", 64'(stray_cnt), 64'(model_stray));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
